glorb_fetch: RTL

Instruction fetch stage directly upstream of the ALU/execute stage.
- Owns the program counter and issues in-order requests to instruction memory.
- Buffers returned instructions in a small FIFO and presents them, with their PC, to execute over a valid/ready handshake.
- Accepts an absolute redirect (taken branch) from execute, then flushes buffered and in-flight instructions.

---
 rtl/glorb_pkg.sv | 20 ++
 rtl/glorb_sync_fifo.sv | 72 +++++++
 rtl/glorb_fetch.sv | 128 ++++++++++++
 3 files changed

// File: rtl/glorb_pkg.sv
// Shared definitions for the glorb fetch stage and its consumers.
package glorb_pkg;

    localparam int GLORB_IW       = 8;
    localparam int GLORB_AW       = 8;
    localparam int GLORB_RESET_PC = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Bundle handed to execute; FIFO entries use the same {pc, insn} packing.
    typedef struct packed {
        logic [GLORB_AW-1:0] pc;
        logic [GLORB_IW-1:0] insn;
    } fetch_bundle_t;

endpackage

// File: rtl/glorb_sync_fifo.sv
// Synchronous FIFO with flush; head entry is read straight from storage flops.
module glorb_sync_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [W-1:0]                 wdata,
    input  logic                         pop,
    output logic [W-1:0]                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_pop;

    assign do_pop = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = wdata;
                wr_d        = wr_q + PW'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign rdata = mem_q[rd_q];
    assign count = cnt_q;
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/glorb_fetch.sv
// Instruction fetch: owns the PC, issues credit-limited in-order requests and
// buffers responses for execute; redirects flush and drop stale responses.
module glorb_fetch
    import glorb_pkg::*;
#(
    parameter int            IW       = GLORB_IW,
    parameter int            AW       = GLORB_AW,
    parameter int            DEPTH    = 2,
    parameter logic [AW-1:0] RESET_PC = AW'(GLORB_RESET_PC)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [AW-1:0] imem_req_addr,
    input  logic          imem_rsp_valid,
    input  logic [IW-1:0] imem_rsp_data,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          insn_valid,
    input  logic          insn_ready,
    output logic [IW-1:0] insn_data,
    output logic [AW-1:0] insn_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] stale_q, stale_d;

    logic [CW-1:0]      fifo_count;
    logic               fifo_full, fifo_empty;
    logic [IW+AW-1:0]   fifo_rdata;
    logic               push, pop, flush, req_accept;
    logic [OW-1:0]      occupancy;

    assign insn_valid = !fifo_empty;
    assign pop        = insn_valid && insn_ready;

    // A slot freed by this cycle's pop is reusable immediately, which is what
    // sustains one instruction per cycle with a one-cycle memory.
    assign occupancy      = OW'(fifo_count) + OW'(outst_q) - OW'(pop);
    assign imem_req_valid = (state_q == ST_FETCH) && (occupancy < OW'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_accept     = imem_req_valid && imem_req_ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        stale_d  = stale_q;
        push     = 1'b0;
        flush    = 1'b0;
        outst_d  = outst_q + CW'(req_accept) - CW'(imem_rsp_valid);

        if (req_accept) begin
            pc_d = pc_q + AW'(1);
        end
        if (imem_rsp_valid) begin
            if (stale_q != '0) begin
                stale_d = stale_q - CW'(1);
            end else begin
                push     = 1'b1;
                rsp_pc_d = rsp_pc_q + AW'(1);
            end
        end

        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: state_d = ST_FETCH;
            ST_DRAIN: if (stale_d == '0) state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase

        // Everything still in flight after this cycle becomes stale.
        if (redirect_valid) begin
            flush    = 1'b1;
            push     = 1'b0;
            pc_d     = redirect_pc;
            rsp_pc_d = redirect_pc;
            stale_d  = outst_d;
            state_d  = (outst_d != '0) ? ST_DRAIN : ST_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outst_q  <= '0;
            stale_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            outst_q  <= outst_d;
            stale_q  <= stale_d;
        end
    end

    glorb_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (IW + AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .wdata ({rsp_pc_q, imem_rsp_data}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign insn_data = fifo_rdata[IW-1:0];
    assign insn_pc   = fifo_rdata[IW+AW-1:IW];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full && !pop));

endmodule
